// File: rtl/wb_grf.sv
// Writeback register file: 32x32 GPRs with reg 0 hard-wired to zero, plus commit trace (last_*) and a commit counter.
// Define GRF_BYPASS_EN to forward the in-flight writeback data to same-cycle reads.
module wb_grf #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             W_regwe,
   input  logic [4:0]       W_A3,
   input  logic [31:0]      W_regwd,
   input  logic [31:0]      W_pc,
   input  logic [4:0]       D_A1,
   input  logic [4:0]       D_A2,
   output logic [31:0]      D_RD1,
   output logic [31:0]      D_RD2,
   output logic [31:0]      last_pc,
   output logic [4:0]       last_A3,
   output logic [31:0]      last_wd,
   output logic [CNT_W-1:0] commit_cnt
);

   logic [31:0]      regs_q [32];
   logic [31:0]      last_pc_q, last_pc_d;
   logic [4:0]       last_a3_q, last_a3_d;
   logic [31:0]      last_wd_q, last_wd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             commit;
   logic             byp1, byp2;

   // Writes to r0 are dropped entirely, so they never touch the trace or counter.
   assign commit = W_regwe && (W_A3 != 5'd0);

   always_comb begin
      last_pc_d = last_pc_q;
      last_a3_d = last_a3_q;
      last_wd_d = last_wd_q;
      cnt_d     = cnt_q;
      if (commit) begin
         last_pc_d = W_pc;
         last_a3_d = W_A3;
         last_wd_d = W_regwd;
         cnt_d     = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         last_pc_q <= '0;
         last_a3_q <= '0;
         last_wd_q <= '0;
         cnt_q     <= '0;
      end else begin
         if (commit) begin
            regs_q[W_A3] <= W_regwd;
         end
         last_pc_q <= last_pc_d;
         last_a3_q <= last_a3_d;
         last_wd_q <= last_wd_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef GRF_BYPASS_EN
   assign byp1 = commit && (D_A1 == W_A3);
   assign byp2 = commit && (D_A2 == W_A3);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   // Reset gates the read ports so forwarded data cannot leak out while reset is held.
   always_comb begin
      D_RD1 = '0;
      D_RD2 = '0;
      if (reset) begin
         if (byp1)               D_RD1 = W_regwd;
         else if (D_A1 != 5'd0)  D_RD1 = regs_q[D_A1];
         if (byp2)               D_RD2 = W_regwd;
         else if (D_A2 != 5'd0)  D_RD2 = regs_q[D_A2];
      end
   end

   assign last_pc    = last_pc_q;
   assign last_A3    = last_a3_q;
   assign last_wd    = last_wd_q;
   assign commit_cnt = cnt_q;

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CNT_W, default 32, width of the commit counter.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 The block SHALL have port W_regwe, input, 1, writeback enable from the W pipeline register.
REQ-005 The block SHALL have port W_A3, input, 5, writeback destination register number.
REQ-006 The block SHALL have port W_regwd, input, 32, writeback data.
REQ-007 The block SHALL have port W_pc, input, 32, PC of the retiring instruction.
REQ-008 The block SHALL have ports D_A1 and D_A2, input, 5 each, decode-stage read addresses.
REQ-009 The block SHALL have ports D_RD1 and D_RD2, output, 32 each, read data for D_A1 and D_A2.
REQ-010 The block SHALL have port last_pc, output, 32, W_pc of the most recent committed write.
REQ-011 The block SHALL have port last_A3, output, 5, destination register of the most recent committed write.
REQ-012 The block SHALL have port last_wd, output, 32, data of the most recent committed write.
REQ-013 The block SHALL have port commit_cnt, output, CNT_W, number of committed writes since reset.

Function
REQ-014 The storage SHALL be 32 x 32-bit registers; register 0 SHALL always read 0 and is never written.
REQ-015 A committed write SHALL be a cycle with W_regwe=1 and W_A3!=0; only a committed write updates state.
REQ-016 On a committed write, regs[W_A3] SHALL be updated with W_regwd at the rising clk edge.
REQ-017 Reads SHALL be combinational: D_RDn = 0 if D_An==0, else regs[D_An] (subject to REQ-022).
REQ-018 On a committed write, last_pc, last_A3 and last_wd SHALL load W_pc, W_A3 and W_regwd on the same edge.
REQ-019 On a committed write, commit_cnt SHALL increment by 1, wrapping from 2^CNT_W-1 to 0 with no flag.
REQ-020 A cycle with W_regwe=1 and W_A3=0 SHALL change no state: no register, last_*, or counter update.
REQ-021 Back-to-back writes to the same register SHALL each commit in order; the last value wins.

Reset
REQ-023 While reset=0, asynchronously and regardless of clk, all 31 writable registers SHALL clear to 0.
REQ-024 While reset=0, last_pc, last_A3, last_wd and commit_cnt SHALL clear to 0.
REQ-025 A write presented during the edge at which reset is low SHALL be discarded.
REQ-026 After reset deasserts, the first rising edge SHALL process inputs normally.
REQ-027 D_RD1 and D_RD2 SHALL read 0 throughout reset, bypass included.

Configuration
REQ-022 With macro GRF_BYPASS_EN defined, a read whose D_An equals W_A3 in a committed-write cycle SHALL return W_regwd combinationally, so the reader sees the value being written.
REQ-028 With GRF_BYPASS_EN undefined, reads SHALL return only stored register contents; the new value is visible from the cycle after the write.
REQ-029 GRF_BYPASS_EN SHALL affect no state update, counter, or last_* behaviour.

Verification
REQ-030 Reset low mid-run: write regs[5]=0x1234, then pulse reset low between edges -> D_RD1 (D_A1=5)=0 immediately; commit_cnt=0; last_*=0.
REQ-031 Write W_A3=8, W_regwd=0xDEADBEEF, W_pc=0x3000 -> next cycle D_RD2 (D_A2=8)=0xDEADBEEF; last_pc=0x3000; last_A3=8; commit_cnt=1.
REQ-032 Write W_A3=0, W_regwd=0xFFFFFFFF, W_regwe=1 -> D_RD1 (D_A1=0)=0; commit_cnt unchanged; last_* unchanged.
REQ-033 Same-cycle read: W_A3=9, W_regwd=0x55 committed while D_A1=9 and regs[9]=0x11 -> D_RD1=0x55 with GRF_BYPASS_EN, 0x11 without; 0x55 on the next cycle in both builds.
REQ-034 Consecutive cycles write reg 3 with 0xA then 0xB -> regs[3]=0xB; commit_cnt increases by 2.
REQ-035 With CNT_W=4, 16 committed writes from reset -> commit_cnt=0 (wrap); the 17th write -> commit_cnt=1.
